// File: rtl/arith_pkg.sv
// Shared arithmetic-unit package: FSM state encoding common to the sequential
// Multiplier and divider, plus the iteration-counter width helper.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of a counter that spans 0..bits-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/divider_pkg.sv
// Divider-local types built on the shared arithmetic encoding.
package divider_pkg;

  import arith_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/divider_if.sv
// Start/finished handshake and operand/result bus of the sequential divider.
//   i_start, i_dividend, i_divisor : requester -> divider
//   o_finished, o_quotient, o_remainder (, o_div_by_zero) : divider -> requester
// o_div_by_zero exists only when DIVIDER_DIV_ZERO_EN is defined.
interface divider_if #(
  parameter int unsigned BITS = 4
);

  logic            i_start;
  logic            o_finished;
  logic [BITS-1:0] i_dividend;
  logic [BITS-1:0] i_divisor;
  logic [BITS-1:0] o_quotient;
  logic [BITS-1:0] o_remainder;
`ifdef DIVIDER_DIV_ZERO_EN
  logic            o_div_by_zero;
`endif

  modport master (
    output i_start,
    output i_dividend,
    output i_divisor,
`ifdef DIVIDER_DIV_ZERO_EN
    input  o_div_by_zero,
`endif
    input  o_finished,
    input  o_quotient,
    input  o_remainder
  );

  modport slave (
    input  i_start,
    input  i_dividend,
    input  i_divisor,
`ifdef DIVIDER_DIV_ZERO_EN
    output o_div_by_zero,
`endif
    output o_finished,
    output o_quotient,
    output o_remainder
  );

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration (combinational).
//   r_i       : partial remainder, BITS+1 bits
//   divisor_i : divisor
//   bit_i     : next dividend bit (msb first)
//   r_o       : updated partial remainder
//   q_o       : quotient bit produced by this iteration
module divider_step #(
  parameter int unsigned BITS = 4
) (
  input  logic [BITS:0]   r_i,
  input  logic [BITS-1:0] divisor_i,
  input  logic            bit_i,
  output logic [BITS:0]   r_o,
  output logic            q_o
);

  logic [BITS:0]   shifted_c;
  logic [BITS+1:0] trial_c;
  // The remainder msb is always zero after a restore; it is shifted out here.
  logic            unused_msb_c;

  assign unused_msb_c = r_i[BITS];

  // Shift in the next dividend bit, then try subtracting the divisor; a
  // borrow out of the extra top bit means the trial went negative.
  always_comb begin
    shifted_c = {r_i[BITS-1:0], bit_i};
    trial_c   = {1'b0, shifted_c} - {2'b00, divisor_i};
    q_o       = ~trial_c[BITS+1];
    r_o       = q_o ? trial_c[BITS:0] : shifted_c;
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset, aborts any division in progress
//   bus     : divider_if.slave (start/finished handshake, operands, results)
// Optional feature macro DIVIDER_DIV_ZERO_EN: adds o_div_by_zero and completes
// a zero-divisor request one edge after acceptance.
module divider
  import arith_pkg::*;
  import divider_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic   i_clock,
  input  logic   i_reset,
  divider_if.slave bus
);

  localparam int unsigned CW = cnt_width(BITS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] dvd_q, dvd_d;
  logic [BITS-1:0] dsr_q, dsr_d;
  logic [BITS:0]   rem_q, rem_d;
  logic [BITS-1:0] quo_q, quo_d;
  logic [BITS-1:0] quotient_q, quotient_d;
  logic [BITS-1:0] remainder_q, remainder_d;
  logic            finished_q, finished_d;
`ifdef DIVIDER_DIV_ZERO_EN
  logic            dbz_q, dbz_d;
`endif

  logic [BITS:0]   step_r_c;
  logic            step_q_c;
  logic [BITS-1:0] quo_next_c;

  divider_step #(.BITS(BITS)) u_step (
    .r_i       (rem_q),
    .divisor_i (dsr_q),
    .bit_i     (dvd_q[BITS-1]),
    .r_o       (step_r_c),
    .q_o       (step_q_c)
  );

  assign quo_next_c = BITS'({quo_q, step_q_c});

  // Next-state, datapath and result update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    finished_d  = 1'b0;
`ifdef DIVIDER_DIV_ZERO_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          state_d = S_RUN;
          dvd_d   = bus.i_dividend;
          dsr_d   = bus.i_divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef DIVIDER_DIV_ZERO_EN
        if (dsr_q == '0) begin
          // Dividend is still unshifted on the first RUN edge.
          state_d     = S_DONE;
          finished_d  = 1'b1;
          quotient_d  = '1;
          remainder_d = dvd_q;
          dbz_d       = 1'b1;
        end else
`endif
        begin
          dvd_d = dvd_q << 1;
          rem_d = step_r_c;
          quo_d = quo_next_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BITS - 1)) begin
            state_d     = S_DONE;
            finished_d  = 1'b1;
            quotient_d  = quo_next_c;
            remainder_d = step_r_c[BITS-1:0];
`ifdef DIVIDER_DIV_ZERO_EN
            dbz_d       = 1'b0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      finished_q  <= 1'b0;
`ifdef DIVIDER_DIV_ZERO_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      finished_q  <= finished_d;
`ifdef DIVIDER_DIV_ZERO_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.o_finished  = finished_q;
  assign bus.o_quotient  = quotient_q;
  assign bus.o_remainder = remainder_q;
`ifdef DIVIDER_DIV_ZERO_EN
  assign bus.o_div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (BITS=4, clock period 2).
module tb_divider;

  localparam int unsigned BITS = 4;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   prev_q = 0;
  int   prev_r = 0;

  always #1 clk = ~clk;

  divider_if #(.BITS(BITS)) bus();

  divider #(.BITS(BITS)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor yields all-ones / dividend.
  task automatic model(input int a, input int b, output int q, output int r, output int lat);
    if (b == 0) begin
      q = (1 << BITS) - 1;
      r = a;
`ifdef DIVIDER_DIV_ZERO_EN
      lat = 1;
`else
      lat = BITS;
`endif
    end else begin
      q   = a / b;
      r   = a % b;
      lat = BITS;
    end
  endtask

  // One division with a single-cycle start; poke re-asserts i_start during RUN.
  task automatic run_div(input int a, input int b, input bit poke, input string tag);
    int q, r, lat, k, extra;
    model(a, b, q, r, lat);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = BITS'(a);
    bus.i_divisor  = BITS'(b);
    @(negedge clk);
    bus.i_dividend = BITS'($urandom);
    bus.i_divisor  = BITS'($urandom);
    check({tag, "_hold_q"}, bus.o_quotient, prev_q);
    check({tag, "_hold_r"}, bus.o_remainder, prev_r);
    k = 0;
    while (bus.o_finished !== 1'b1 && k < TIMEOUT) begin
      bus.i_start = poke && (k >= 1) && (k <= int'(BITS) - 1);
      @(negedge clk);
      k++;
    end
    bus.i_start = 1'b0;
    check({tag, "_lat"}, k, lat);
    check({tag, "_q"}, bus.o_quotient, q);
    check({tag, "_r"}, bus.o_remainder, r);
`ifdef DIVIDER_DIV_ZERO_EN
    check({tag, "_dbz"}, bus.o_div_by_zero, (b == 0) ? 1 : 0);
`endif
    prev_q = q;
    prev_r = r;
    @(negedge clk);
    check({tag, "_pulse_end"}, bus.o_finished, 0);
    if (poke) begin
      extra = 0;
      repeat (2 * BITS) begin
        @(negedge clk);
        if (bus.o_finished === 1'b1) extra++;
      end
      check({tag, "_extra_pulses"}, extra, 0);
    end
  endtask

  initial begin
    int k, j, pulses, a, b;
    rst = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_q", bus.o_quotient, 0);
    check("rst_r", bus.o_remainder, 0);
    check("rst_fin", bus.o_finished, 0);
`ifdef DIVIDER_DIV_ZERO_EN
    check("rst_dbz", bus.o_div_by_zero, 0);
`endif
    rst = 1'b0;

    // Basic division.
    run_div(14, 3, 1'b0, "t1");

    // Back-to-back with i_start held; operand changes after acceptance.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 4'd15; bus.i_divisor = 4'd1;
    @(negedge clk);
    bus.i_dividend = 4'd2; bus.i_divisor = 4'd11;
    k = 0;
    while (bus.o_finished !== 1'b1 && k < TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    check("t2a_lat", k, BITS);
    check("t2a_q", bus.o_quotient, 15);
    check("t2a_r", bus.o_remainder, 0);
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_dividend = 4'd7; bus.i_divisor = 4'd7;
    check("t2_gap_low", bus.o_finished, 0);
    j = 1;
    while (bus.o_finished !== 1'b1 && j < TIMEOUT) begin
      @(negedge clk);
      j++;
    end
    check("t2_gap", j, BITS + 1);
    check("t2b_q", bus.o_quotient, 0);
    check("t2b_r", bus.o_remainder, 2);
    prev_q = 0; prev_r = 2;

    // Divide by zero.
    run_div(9, 0, 1'b0, "t3");

    // Reset mid-RUN aborts without a completion pulse.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dividend = 4'd13; bus.i_divisor = 4'd5;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_q", bus.o_quotient, 0);
    check("t4_r", bus.o_remainder, 0);
    check("t4_fin", bus.o_finished, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_finished === 1'b1) pulses++;
    end
    check("t4_no_pulse", pulses, 0);
    prev_q = 0; prev_r = 0;
    run_div(13, 5, 1'b0, "t4b");

    // i_start pulsed during RUN is ignored.
    run_div(11, 2, 1'b1, "t6a");
    run_div(15, 4, 1'b1, "t6b");

    // Exhaustive nonzero divisors.
    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 16; y++)
        run_div(x, y, 1'b0, "exh");

    // Randomized operands, including zero divisors and stray starts.
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      run_div(a, b, (b != 0) && ($urandom_range(0, 1) == 1), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
